// File: rtl/instr_fetch_pkg.sv
// Shared types for the fetch stage and the multi-cycle control FSM it feeds.
package instr_fetch_pkg;

   // Control FSM states; the fetch stage only acts while the FSM sits in FETCH.
   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEMORY    = 3'd3,
      WRITEBACK = 3'd4
   } state_t;

   // RV32I major opcodes (instr[6:0]) used by the control FSM for branching.
   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_I_TYPE = 7'b0010011,
      OP_AUIPC  = 7'b0010111,
      OP_STORE  = 7'b0100011,
      OP_R_TYPE = 7'b0110011,
      OP_LUI    = 7'b0110111,
      OP_BRANCH = 7'b1100011,
      OP_JALR   = 7'b1100111,
      OP_JAL    = 7'b1101111
   } opcode_t;

   // Internal fetch sequencer states.
   typedef enum logic [2:0] {
      F_IDLE = 3'd0,
      F_REQ  = 3'd1,
      F_WAIT = 3'd2,
      F_DONE = 3'd3,
      F_ERR  = 3'd4
   } fetch_state_t;

   // Reported fault cause; the encoding is visible on the fault_cause port.
   typedef enum logic [1:0] {
      FF_NONE     = 2'd0,
      FF_MISALIGN = 2'd1,
      FF_BUSERR   = 2'd2,
      FF_TIMEOUT  = 2'd3
   } fetch_fault_t;

   // addi x0, x0, 0 -- the instruction register holds this out of reset.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Major opcode field of an instruction word.
   function automatic opcode_t get_opcode(input logic [31:0] ins);
      return opcode_t'(ins[6:0]);
   endfunction

endpackage

// File: rtl/fetch_timeout_cnt.sv
// Wait-cycle counter for the fetch stage. Cleared when a request is granted,
// counts every enabled cycle, and flags the TIMEOUT-th enabled cycle as the
// terminal cycle (tc). It holds at the terminal value rather than wrapping.
module fetch_timeout_cnt
   import instr_fetch_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The counter reads 0 in the first wait cycle, so TIMEOUT-1 marks the last one.
   assign tc = en && (cnt_q == CNT_W'(TIMEOUT - 1));

   // Next count: clear wins, otherwise step while enabled and not terminal.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !tc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage. While the control FSM is in FETCH it reads one
// word from instruction memory and latches it into the instruction register,
// then pulses state_finish for one cycle.
// Memory handshake: imem_req/imem_addr are held stable from the first request
// cycle until the cycle imem_gnt is sampled high (the transfer). The response
// arrives later as a single imem_rvalid cycle; imem_rdata and imem_err are
// only meaningful in that cycle, and an rvalid in the grant cycle is ignored.
// Misaligned PCs, bus errors and response timeouts park the stage in a sticky
// fault state that only rst leaves.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  state_t            now_state,
   input  logic [ADDR_W-1:0] pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_err,
   output logic [31:0]       instr,
   output opcode_t           opcode,
   output logic              state_finish,
   output logic              fetch_fault,
   output logic [1:0]        fault_cause
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       instr_q, instr_d;
   fetch_fault_t      cause_q, cause_d;

   logic cnt_clr;
   logic cnt_en;
   logic cnt_tc;

   // The wait counter restarts on the grant and runs only while awaiting data.
   assign cnt_clr = (state_q == F_REQ) && imem_gnt;
   assign cnt_en  = (state_q == F_WAIT);

   fetch_timeout_cnt #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timeout_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .tc  (cnt_tc)
   );

   // Next-state, datapath updates and state-decoded outputs.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      instr_d      = instr_q;
      cause_d      = cause_q;
      imem_req     = 1'b0;
      imem_addr    = addr_q;
      state_finish = 1'b0;
      fetch_fault  = 1'b0;
      fault_cause  = cause_q;
      instr        = instr_q;
      opcode       = get_opcode(instr_q);

      case (state_q)
         F_IDLE: begin
            if (now_state == FETCH) begin
               addr_d = pc;
               if (pc[1:0] != 2'b00) begin
                  state_d = F_ERR;
                  cause_d = FF_MISALIGN;
               end else begin
                  state_d = F_REQ;
               end
            end
         end
         F_REQ: begin
            imem_req = 1'b1;
            if (imem_gnt) begin
               state_d = F_WAIT;
            end
         end
         F_WAIT: begin
            // A response in the terminal cycle still counts as on time.
            if (imem_rvalid) begin
               if (imem_err) begin
                  state_d = F_ERR;
                  cause_d = FF_BUSERR;
               end else begin
                  instr_d = imem_rdata;
                  state_d = F_DONE;
               end
            end else if (cnt_tc) begin
               state_d = F_ERR;
               cause_d = FF_TIMEOUT;
            end
         end
         F_DONE: begin
            // The control FSM leaves FETCH on this edge, so idle is safe.
            state_finish = 1'b1;
            state_d      = F_IDLE;
         end
         F_ERR: begin
            fetch_fault = 1'b1;
         end
         default: begin
            state_d = F_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= F_IDLE;
         addr_q  <= '0;
         instr_q <= NOP_INSTR;
         cause_q <= FF_NONE;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         cause_q <= cause_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized fetches checked
// against a transaction-level timing model and an expected-instruction queue.
// Cycle 0 is the first cycle now_state==FETCH; outputs are sampled on the
// falling edge, after which the inputs for that cycle are driven.
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 8;
   localparam int MAXC    = 64;

   // ---------------- clock / reset / DUT ----------------
   logic              clk = 1'b0;
   logic              rst;
   state_t            now_state;
   logic [ADDR_W-1:0] pc;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [31:0]       imem_rdata;
   logic              imem_err;
   logic [31:0]       instr;
   opcode_t           opcode;
   logic              state_finish;
   logic              fetch_fault;
   logic [1:0]        fault_cause;

   always #5 clk = ~clk;

   instr_fetch #(
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .now_state    (now_state),
      .pc           (pc),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_gnt     (imem_gnt),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .imem_err     (imem_err),
      .instr        (instr),
      .opcode       (opcode),
      .state_finish (state_finish),
      .fetch_fault  (fetch_fault),
      .fault_cause  (fault_cause)
   );

   // ---------------- bookkeeping ----------------
   int tests_run    = 0;
   int tests_failed = 0;

   logic [31:0] exp_q[$];
   logic [31:0] model_instr;

   // Per-fetch observation record filled by drive_fetch.
   logic        req_tr   [0:MAXC-1];
   logic        flt_tr   [0:MAXC-1];
   logic [1:0]  cause_tr [0:MAXC-1];
   logic [31:0] instr_tr [0:MAXC-1];
   int first_fin, fin_cnt, first_flt, req_cnt, addr_bad, last_c;

   // Transaction-level prediction of one fetch.
   typedef struct {
      int          fin;
      int          flt;
      logic [1:0]  cause;
      int          req_cnt;
      logic [31:0] instr;
   } pred_t;

   // Request in cycles 1..1+gd, grant at g=1+gd, response rd cycles later.
   // Data is accepted up to TIMEOUT cycles after the grant; otherwise the
   // timeout fault appears the cycle after the TIMEOUT-th wait cycle.
   function automatic pred_t predict(input logic [31:0] p, input int gd, input int rd,
                                     input logic e, input logic [31:0] d,
                                     input logic [31:0] cur);
      pred_t r;
      int g;
      r.fin = -1; r.flt = -1; r.cause = 2'd0; r.req_cnt = 0; r.instr = cur;
      if (p[1:0] != 2'b00) begin
         r.flt = 1; r.cause = 2'd1;
      end else begin
         g = 1 + gd;
         r.req_cnt = gd + 1;
         if (rd <= TIMEOUT) begin
            if (e) begin
               r.flt = g + rd + 1; r.cause = 2'd2;
            end else begin
               r.fin = g + rd + 1; r.instr = d;
            end
         end else begin
            r.flt = g + TIMEOUT + 1; r.cause = 2'd3;
         end
      end
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1; now_state = DECODE; pc = '0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_err = 1'b0; imem_rdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_instr = NOP_INSTR;
      exp_q.delete();
   endtask

   // Runs one fetch: grant gd cycles after the first request cycle, response
   // rd cycles after the grant. Records what the DUT shows each cycle.
   task automatic drive_fetch(input logic [31:0] p, input int gd, input int rd,
                              input logic e, input logic [31:0] d);
      int g, r, n;
      g = 1 + gd; r = g + rd; n = gd + TIMEOUT + 5;
      first_fin = -1; fin_cnt = 0; first_flt = -1; req_cnt = 0; addr_bad = 0;
      @(negedge clk);
      now_state = FETCH; pc = p;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_err = 1'b0; imem_rdata = $urandom;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         req_tr[c] = imem_req; flt_tr[c] = fetch_fault;
         cause_tr[c] = fault_cause; instr_tr[c] = instr;
         if (imem_req) begin
            req_cnt++;
            if (imem_addr !== p) addr_bad++;
         end
         if (state_finish) begin
            fin_cnt++;
            if (first_fin < 0) first_fin = c;
         end
         if (fetch_fault && first_flt < 0) first_flt = c;
         if (state_finish || fetch_fault) now_state = DECODE;
         imem_gnt    = (c == g);
         imem_rvalid = (c == r);
         imem_err    = (c == r) ? e : 1'($urandom_range(0, 1));
         imem_rdata  = (c == r) ? d : $urandom;
      end
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_err = 1'b0;
      last_c = n;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %0b want 0", imem_req); end
      tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
      tests_run++; if (instr !== 32'h0000_0013) begin tests_failed++; $display("FAIL reset_instr: got %h want 00000013", instr); end
      tests_run++; if (state_finish !== 1'b0) begin tests_failed++; $display("FAIL reset_finish: got %0b want 0", state_finish); end
      tests_run++; if (fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL reset_fault: got %0b want 0", fetch_fault); end
      tests_run++; if (fault_cause !== 2'd0) begin tests_failed++; $display("FAIL reset_cause: got %0d want 0", fault_cause); end
   endtask

   task automatic test_zero_wait();
      drive_fetch(32'h100, 0, 1, 1'b0, 32'h0050_0093);
      tests_run++; if (req_tr[1] !== 1'b1) begin tests_failed++; $display("FAIL zw_req_c1: got %0b want 1", req_tr[1]); end
      tests_run++; if (req_cnt != 1 || addr_bad != 0) begin tests_failed++; $display("FAIL zw_req: got %0d cycles %0d bad addr want 1 and 0", req_cnt, addr_bad); end
      tests_run++; if (first_fin != 3 || fin_cnt != 1) begin tests_failed++; $display("FAIL zw_finish: got cycle %0d count %0d want 3 and 1", first_fin, fin_cnt); end
      tests_run++; if (instr !== 32'h0050_0093) begin tests_failed++; $display("FAIL zw_instr: got %h want 00500093", instr); end
      tests_run++; if (opcode !== OP_I_TYPE) begin tests_failed++; $display("FAIL zw_opcode: got %b want %b", opcode, OP_I_TYPE); end
      tests_run++; if (first_flt != -1) begin tests_failed++; $display("FAIL zw_fault: got cycle %0d want none", first_flt); end
      model_instr = 32'h0050_0093;
   endtask

   task automatic test_grant_stall();
      logic [31:0] d;
      d = {$urandom, 7'b0110011} [31:0];
      drive_fetch(32'h104, 4, 1, 1'b0, d);
      tests_run++; if (req_cnt != 5 || addr_bad != 0) begin tests_failed++; $display("FAIL gs_req: got %0d cycles %0d bad addr want 5 and 0", req_cnt, addr_bad); end
      tests_run++; if (req_tr[5] !== 1'b1 || req_tr[6] !== 1'b0) begin tests_failed++; $display("FAIL gs_req_window: got c5=%0b c6=%0b want 1 0", req_tr[5], req_tr[6]); end
      tests_run++; if (first_fin != 7 || fin_cnt != 1) begin tests_failed++; $display("FAIL gs_finish: got cycle %0d count %0d want 7 and 1", first_fin, fin_cnt); end
      tests_run++; if (instr !== d) begin tests_failed++; $display("FAIL gs_instr: got %h want %h", instr, d); end
      model_instr = d;
   endtask

   task automatic test_bus_error();
      logic [31:0] d1;
      d1 = $urandom;
      drive_fetch(32'h200, 1, 2, 1'b0, d1);
      drive_fetch(32'h204, 0, 3, 1'b1, $urandom);
      tests_run++; if (first_flt != 5) begin tests_failed++; $display("FAIL be_fault_cycle: got %0d want 5", first_flt); end
      tests_run++; if (cause_tr[5] !== 2'd2) begin tests_failed++; $display("FAIL be_cause: got %0d want 2", cause_tr[5]); end
      tests_run++; if (fin_cnt != 0) begin tests_failed++; $display("FAIL be_finish: got %0d pulses want 0", fin_cnt); end
      tests_run++; if (instr !== d1) begin tests_failed++; $display("FAIL be_instr_kept: got %h want %h", instr, d1); end
      tests_run++; if (flt_tr[last_c] !== 1'b1) begin tests_failed++; $display("FAIL be_sticky: got %0b want 1", flt_tr[last_c]); end
   endtask

   task automatic test_misaligned();
      do_reset();
      drive_fetch(32'h102, 0, 1, 1'b0, $urandom);
      tests_run++; if (req_cnt != 0) begin tests_failed++; $display("FAIL ma_req: got %0d cycles want 0", req_cnt); end
      tests_run++; if (first_flt != 1 || cause_tr[1] !== 2'd1) begin tests_failed++; $display("FAIL ma_fault: got cycle %0d cause %0d want 1 and 1", first_flt, cause_tr[1]); end
      tests_run++; if (fin_cnt != 0) begin tests_failed++; $display("FAIL ma_finish: got %0d pulses want 0", fin_cnt); end
   endtask

   task automatic test_timeout();
      do_reset();
      drive_fetch(32'h300, 0, TIMEOUT + 3, 1'b0, $urandom);
      tests_run++; if (first_flt != TIMEOUT + 2) begin tests_failed++; $display("FAIL to_fault_cycle: got %0d want %0d", first_flt, TIMEOUT + 2); end
      tests_run++; if (cause_tr[TIMEOUT + 2] !== 2'd3) begin tests_failed++; $display("FAIL to_cause: got %0d want 3", cause_tr[TIMEOUT + 2]); end
      tests_run++; if (fin_cnt != 0 || instr !== NOP_INSTR) begin tests_failed++; $display("FAIL to_late_data: got %0d pulses instr %h want 0 and 00000013", fin_cnt, instr); end
   endtask

   task automatic test_race();
      logic [31:0] d;
      do_reset();
      d = $urandom;
      drive_fetch(32'h400, 2, TIMEOUT, 1'b0, d);
      tests_run++; if (first_flt != -1) begin tests_failed++; $display("FAIL race_fault: got cycle %0d want none", first_flt); end
      tests_run++; if (first_fin != TIMEOUT + 4 || fin_cnt != 1) begin tests_failed++; $display("FAIL race_finish: got cycle %0d count %0d want %0d and 1", first_fin, fin_cnt, TIMEOUT + 4); end
      tests_run++; if (instr !== d) begin tests_failed++; $display("FAIL race_instr: got %h want %h", instr, d); end
   endtask

   task automatic test_reset_mid_wait();
      int stray;
      do_reset();
      drive_fetch(32'h500, 0, 1, 1'b0, 32'hDEAD_BEEF);
      @(negedge clk); now_state = FETCH; pc = 32'h504;       // cycle 0
      @(negedge clk); imem_gnt = 1'b1;                        // cycle 1: request
      @(negedge clk); imem_gnt = 1'b0;                        // cycle 2: waiting
      @(negedge clk); rst = 1'b1; now_state = DECODE;        // cycle 3: waiting
      @(negedge clk);                                         // cycle 4
      tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL rmw_req: got %0b want 0", imem_req); end
      tests_run++; if (instr !== 32'h0000_0013) begin tests_failed++; $display("FAIL rmw_instr: got %h want 00000013", instr); end
      rst = 1'b0; imem_rvalid = 1'b1; imem_err = 1'b0; imem_rdata = $urandom;
      stray = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         imem_rvalid = 1'b0;
         if (state_finish || imem_req || fetch_fault) stray++;
      end
      tests_run++; if (stray != 0) begin tests_failed++; $display("FAIL rmw_stray: got %0d active cycles want 0", stray); end
   endtask

   task automatic test_random();
      pred_t       p;
      logic [31:0] a, d, got;
      int          gd, rd;
      logic        e, mis;
      do_reset();
      for (int i = 0; i < 24; i++) begin
         mis = ($urandom_range(0, 7) == 0);
         a   = ($urandom & 32'h0000_FFFC) | (mis ? 32'($urandom_range(1, 3)) : 32'h0);
         gd  = $urandom_range(0, 3);
         rd  = $urandom_range(1, TIMEOUT + 2);
         e   = ($urandom_range(0, 7) == 0);
         d   = $urandom;
         p   = predict(a, gd, rd, e, d, model_instr);
         if (p.fin >= 0) exp_q.push_back(d);
         drive_fetch(a, gd, rd, e, d);
         tests_run++; if (first_fin != p.fin || fin_cnt != (p.fin >= 0 ? 1 : 0)) begin tests_failed++; $display("FAIL rnd%0d_finish: got cycle %0d count %0d want %0d", i, first_fin, fin_cnt, p.fin); end
         tests_run++; if (first_flt != p.flt) begin tests_failed++; $display("FAIL rnd%0d_fault: got cycle %0d want %0d", i, first_flt, p.flt); end
         if (first_flt >= 0) begin
            tests_run++; if (cause_tr[first_flt] !== p.cause) begin tests_failed++; $display("FAIL rnd%0d_cause: got %0d want %0d", i, cause_tr[first_flt], p.cause); end
         end
         tests_run++; if (req_cnt != p.req_cnt || addr_bad != 0) begin tests_failed++; $display("FAIL rnd%0d_req: got %0d cycles %0d bad addr want %0d and 0", i, req_cnt, addr_bad, p.req_cnt); end
         tests_run++; if (instr !== p.instr) begin tests_failed++; $display("FAIL rnd%0d_instr: got %h want %h", i, instr, p.instr); end
         if (fin_cnt > 0 && exp_q.size() > 0) begin
            got = instr_tr[first_fin];
            tests_run++; if (got !== exp_q.pop_front()) begin tests_failed++; $display("FAIL rnd%0d_sb: got %h want %h", i, got, d); end
         end
         model_instr = p.instr;
         if (p.flt >= 0) do_reset();
      end
      tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL rnd_sb_left: got %0d entries want 0", exp_q.size()); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_zero_wait();
      test_grant_stall();
      test_bus_error();
      test_misaligned();
      test_timeout();
      test_race();
      test_reset_mid_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Hard time limit so a wedged run still terminates.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
